// File: rtl/uart_store_sched_if.sv
// uart_store_sched_if: pipeline-side store ports and uart-side pacing outputs of the UART store scheduler.
interface uart_store_sched_if #(
   parameter int ADDR_W = 4
);
   logic              wr1_valid;
   logic [7:0]        wr1_data;
   logic              wr2_valid;
   logic [7:0]        wr2_data;
   logic              tx_ready;
   logic              uart_wr;
   logic [7:0]        uart_dat;
   logic              stall_req;
   logic [ADDR_W:0]   count;
   logic              overflow;

   modport master (
      output wr1_valid, wr1_data, wr2_valid, wr2_data, tx_ready,
      input  uart_wr, uart_dat, stall_req, count, overflow
   );

   modport slave (
      input  wr1_valid, wr1_data, wr2_valid, wr2_data, tx_ready,
      output uart_wr, uart_dat, stall_req, count, overflow
   );
endinterface

// File: rtl/uart_store_sched.sv
// uart_store_sched: queues dual-slot UART stores in program order and paces them into the uart one byte at a time.
module uart_store_sched #(
   parameter int DEPTH   = 16,
   parameter int ADDR_W  = 4,
   parameter int MIN_GAP = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   uart_store_sched_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEND = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] wr_nxt;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;
   logic [ADDR_W:0]   free;
   logic [1:0]        state;
   logic [3:0]        gap_cnt;
   logic              we0;
   logic              we1;
   logic [7:0]        b0;
   logic              drop;
   logic              pop;
   logic [1:0]        n_push;

   // Free space ignores a same-cycle pop: the popped slot is still being read this edge.
   always_comb begin
      free   = (ADDR_W+1)'(DEPTH) - count;
      wr_nxt = wr_ptr + ADDR_W'(1);
      we0    = (bus.wr1_valid || bus.wr2_valid) && free != '0;
      we1    = bus.wr1_valid && bus.wr2_valid && free >= (ADDR_W+1)'(2);
      b0     = bus.wr1_valid ? bus.wr1_data : bus.wr2_data;
      drop   = ((bus.wr1_valid || bus.wr2_valid) && !we0) || (bus.wr1_valid && bus.wr2_valid && !we1);
      n_push = {1'b0, we0} + {1'b0, we1};
      pop    = state == IDLE && count != '0 && bus.tx_ready;
   end

   assign bus.count     = count;
   assign bus.stall_req = free < (ADDR_W+1)'(2);

   always_ff @(posedge clk) begin
      if (we0) mem[wr_ptr] <= b0;
      if (we1) mem[wr_nxt] <= bus.wr2_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         count        <= '0;
         bus.overflow <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr + ADDR_W'(n_push);
         count  <= count + (ADDR_W+1)'(n_push) - (ADDR_W+1)'(pop);
         if (drop) bus.overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         rd_ptr       <= '0;
         gap_cnt      <= '0;
         bus.uart_wr  <= 1'b0;
         bus.uart_dat <= 8'h00;
      end else begin
         case (state)
            IDLE: if (pop) begin
               bus.uart_wr  <= 1'b1;
               bus.uart_dat <= mem[rd_ptr];
               rd_ptr       <= rd_ptr + ADDR_W'(1);
               state        <= SEND;
            end
            SEND: begin
               bus.uart_wr <= 1'b0;
               gap_cnt     <= 4'(MIN_GAP);
               state       <= (MIN_GAP == 0) ? IDLE : GAP;
            end
            GAP: begin
               gap_cnt <= gap_cnt - 4'd1;
               state   <= (gap_cnt <= 4'd2) ? IDLE : GAP;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
